// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debounce/pulse stage:
// FSM state encoding and default timing parameters.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY  = 0;
    localparam int DEF_REPEAT_PERIOD = 1;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Both stages clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Raw push-button to clean one-cycle count pulse: synchronizer, debounce FSM
// and optional hold-to-auto-repeat. Outputs are registered.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_,
    input  logic btn,
    output logic pulse,
    output logic level
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    // Counters are sized so terminal values are always reachable without wrap.
    if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > CNT_MAX) begin : g_bad_stable
        $error("btn_debounce_pulse: STABLE_CYCLES out of range for CNT_W");
    end
    if (REPEAT_DELAY < 0 || longint'(REPEAT_DELAY) > CNT_MAX) begin : g_bad_delay
        $error("btn_debounce_pulse: REPEAT_DELAY out of range for CNT_W");
    end
    if (REPEAT_PERIOD < 1 || longint'(REPEAT_PERIOD) > CNT_MAX) begin : g_bad_period
        $error("btn_debounce_pulse: REPEAT_PERIOD out of range for CNT_W");
    end
    if (REPEAT_DELAY != 0 && REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_reload
        $error("btn_debounce_pulse: REPEAT_PERIOD must not exceed REPEAT_DELAY");
    end

    localparam bit             REPEAT_EN     = (REPEAT_DELAY != 0);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_RELD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic             btn_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    sync2 u_sync (
        .clk  (clk),
        .rst_ (rst_),
        .d_i  (btn),
        .q_o  (btn_s)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == STABLE_LAST) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    pulse_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                // rcnt advances on every HELD cycle, including the one that
                // leaves for RELEASE_CHK; a suppressed repeat still reloads.
                if (REPEAT_EN) begin
                    if (rcnt_q == REPEAT_LAST) rcnt_d = REPEAT_RELD;
                    else                       rcnt_d = rcnt_q + CNT_W'(1);
                end
                if (!btn_s) begin
                    state_d = RELEASE_CHK;
                    dcnt_d  = '0;
                end else if (REPEAT_EN && rcnt_q == REPEAT_LAST) begin
                    pulse_d = 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                end else if (dcnt_q == STABLE_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
            end
        endcase
        level_d = (state_d == HELD) || (state_d == RELEASE_CHK);
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: doc/btn_debounce_pulse.md
# btn_debounce_pulse

- Upstream conditioning stage for the 4-bit incrementor. It converts a raw, bouncing, asynchronous push-button into a clean single-cycle `pulse` that drives the counter's enable input `d`.
- Contains a 2-flop synchronizer, a four-state debounce FSM and an optional hold-to-auto-repeat generator.
- One button press produces exactly one count step; holding the button produces paced repeat steps.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required to accept a press or a release; must be ≥1.
- `REPEAT_DELAY`, 0: cycles in HELD before the first repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 1: cycles between repeat pulses after the first one; must be ≥1.
- `CNT_W`, 16: width of both internal counters; every cycle parameter must be ≤ 2^CNT_W−1.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_`  input  1  reset, asynchronous and active-low; clears all state immediately.
- `btn`  input  1  raw button, active-high, asynchronous to `clk`.
- `pulse`  output  1  registered one-cycle strobe; connect to incrementor `d`.
- `level`  output  1  registered debounced button state.

## Operation
- Synchronizer: `btn` → s1 → s2 (`btn_s`). Both flops reset to 0. The FSM only looks at `btn_s`.
- Debounce counter `dcnt` (CNT_W bits) is cleared on every state change.
- FSM states:
  - IDLE (reset state): `btn_s`=1 → PRESS_CHK.
  - PRESS_CHK:
    - `btn_s`=0 → IDLE, no pulse.
    - `btn_s`=1 and `dcnt`==STABLE_CYCLES−1 → HELD, assert `pulse`.
    - Otherwise `dcnt`++.
  - HELD:
    - `btn_s`=0 → RELEASE_CHK.
    - Otherwise run the repeat logic.
  - RELEASE_CHK:
    - `btn_s`=1 → HELD, no pulse.
    - `btn_s`=0 and `dcnt`==STABLE_CYCLES−1 → IDLE.
    - Otherwise `dcnt`++.
- Repeat counter `rcnt`:
  - Cleared only on the PRESS_CHK→HELD transition.
  - Counts in HELD and freezes in RELEASE_CHK; a bounce during release does not restart the delay.
  - With REPEAT_DELAY≠0:
    - Pulse when `rcnt` reaches REPEAT_DELAY−1.
    - Thereafter pulse every REPEAT_PERIOD cycles.
    - Implementation: on each repeat pulse, reload `rcnt` to REPEAT_DELAY−REPEAT_PERIOD.
- `level`=1 in HELD and RELEASE_CHK, 0 in IDLE and PRESS_CHK.
- `pulse` is never high for two consecutive cycles unless REPEAT_PERIOD=1 in HELD.
- Reset values: `pulse`=0, `level`=0, state=IDLE, `dcnt`=0, `rcnt`=0, s1=s2=0.
- Reset mid-operation: all outputs drop on `rst_` assertion, without waiting for a clock edge. After release the FSM restarts from IDLE; if the button is still held it must be re-debounced (a full PRESS_CHK pass) before any pulse.

## Timing
- Press latency: with `btn` high and stable from the edge that first samples it (edge 1), `pulse` is high for the single cycle after edge STABLE_CYCLES+3.
  - With the default of 4, that is after edge 7.
  - `level` rises on the same edge as `pulse`.
- Release latency: `level` falls after edge STABLE_CYCLES+3, counted from the first edge that samples `btn`=0.
- Glitch rejection: any `btn` excursion shorter than STABLE_CYCLES synchronized cycles produces no `pulse` and no `level` change.
- Simultaneous events:
  - In PRESS_CHK, a terminal count with `btn_s`=0 on the same edge gives IDLE, no pulse.
  - In HELD, a release on the same edge as a repeat-pulse point suppresses the pulse.
- Counter wrap: cannot occur because of the parameter ≤ 2^CNT_W−1 rule. Simulation must flag any violating parameterization at elaboration.

## Structure
- Shared package/include `btn_debounce_pkg`: state encodings IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, RELEASE_CHK=2'd3, plus default parameter constants.
- Sub-module `sync2`: generic 2-flop synchronizer with `clk` and `rst_`, reset value 0, reusable across the codebase.
- Top level: `sync2`, the FSM, `dcnt`, `rcnt` and output registers. No combinational path from `btn` to any output.

## Test plan
All tests use STABLE_CYCLES=4 unless stated.
- Clean press: REPEAT_DELAY=0, hold `btn`=1 for 20 cycles, then release → exactly one `pulse` (after edge 7); downstream incrementor goes 0→1; `level` 0 again 7 cycles after release.
- Bounce: toggle `btn` 1,0,1,0 with 1-cycle and 3-cycle widths, then hold → no pulse during bouncing; one pulse 7 edges after the final stable rise; count=1.
- Auto-repeat: REPEAT_DELAY=8, REPEAT_PERIOD=3, hold 30 cycles after acceptance → pulses at HELD-entry, +8, +11, +14, …; count after 30 cycles = 1+8 = 9.
- Release bounce: in HELD with REPEAT_DELAY=8, drop `btn_s` for 2 cycles then restore → no extra pulse; `level` stays 1; `rcnt` resumes, so the first repeat arrives 2 cycles late.
- Reset mid-hold: assert `rst_`=0 between clock edges while in HELD → `pulse`/`level` 0 immediately; release reset with `btn` still 1 → next pulse exactly 7 edges later.
- Wrap through incrementor: 16 accepted presses → count goes 15→0; exactly 16 pulses observed.
